// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants and RX state encoding for the PS/2 receiver
package ps2_pkg;
  localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
  localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;
  localparam int ENTRY_W = 10;
  typedef enum logic [1:0] {RX_IDLE, RX_SHIFT, RX_CHECK} rx_state_t;
endpackage

// File: rtl/ps2_sync_fifo.sv
// ps2_sync_fifo: show-ahead synchronous FIFO; push while full is accepted only alongside a pop
module ps2_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     clrn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = empty ? '0 : mem[rp];
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop) rp <= rp + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= wr_data;
endmodule

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: filtered PS/2 device-to-host receiver with timeout, sticky errors and scancode FIFO
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 20000,
  parameter int EVENT_MODE  = 0
) (
  input  logic                          clk,
  input  logic                          clrn,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          rd_en,
  input  logic                          err_clr,
  output logic                          out_valid,
  output logic [7:0]                    out_data,
  output logic                          out_ext,
  output logic                          out_brk,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          parity_err,
  output logic                          frame_err
);
  localparam int FW = $clog2(FILTER_LEN) + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [1:0] s1, s2, filt;
  logic [FW-1:0] fcnt [2];
  logic fclk_q, fall, fdata;
  rx_state_t state;
  logic [3:0] bitcnt;
  logic [9:0] shreg;
  logic [TW-1:0] tcnt;
  logic good_v, ext_l, brk_l, push, full, empty;
  logic [7:0] good_b;
  logic [ENTRY_W-1:0] head;
  // bit 0 is ps2_clk, bit 1 is ps2_data; both idle high out of reset
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      s1 <= '1;
      s2 <= '1;
      filt <= '1;
      fcnt <= '{default: '0};
      fclk_q <= 1'b1;
    end else begin
      s1 <= {ps2_data, ps2_clk};
      s2 <= s1;
      fclk_q <= filt[0];
      for (int i = 0; i < 2; i++)
        if (s2[i] == filt[i]) fcnt[i] <= '0;
        else if (fcnt[i] == FW'(FILTER_LEN - 1)) begin
          filt[i] <= s2[i];
          fcnt[i] <= '0;
        end else fcnt[i] <= fcnt[i] + FW'(1);
    end
  assign fall = fclk_q & ~filt[0];
  assign fdata = filt[1];
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      state <= RX_IDLE;
      bitcnt <= '0;
      shreg <= '0;
      tcnt <= '0;
      good_v <= 1'b0;
      good_b <= '0;
      ext_l <= 1'b0;
      brk_l <= 1'b0;
      parity_err <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      good_v <= 1'b0;
      if (err_clr) begin
        parity_err <= 1'b0;
        frame_err <= 1'b0;
      end
      if (good_v) begin
        if (EVENT_MODE != 0 && good_b == PS2_EXT_PREFIX) ext_l <= 1'b1;
        else if (EVENT_MODE != 0 && good_b == PS2_BRK_PREFIX) brk_l <= 1'b1;
        else begin
          ext_l <= 1'b0;
          brk_l <= 1'b0;
        end
      end
      case (state)
        RX_IDLE:
          if (fall) begin
            if (!fdata) begin
              state <= RX_SHIFT;
              bitcnt <= 4'd1;
              tcnt <= '0;
            end else begin
              frame_err <= 1'b1;
              ext_l <= 1'b0;
              brk_l <= 1'b0;
            end
          end
        RX_SHIFT:
          if (fall) begin
            shreg <= {fdata, shreg[9:1]};
            tcnt <= '0;
            bitcnt <= bitcnt + 4'd1;
            if (bitcnt == 4'd10) state <= RX_CHECK;
          end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
            frame_err <= 1'b1;
            ext_l <= 1'b0;
            brk_l <= 1'b0;
            state <= RX_IDLE;
          end else tcnt <= tcnt + TW'(1);
        RX_CHECK: begin
          state <= RX_IDLE;
          if (!(^shreg[8:0])) parity_err <= 1'b1;
          if (!shreg[9]) frame_err <= 1'b1;
          if ((^shreg[8:0]) && shreg[9]) begin
            good_v <= 1'b1;
            good_b <= shreg[7:0];
          end else begin
            ext_l <= 1'b0;
            brk_l <= 1'b0;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  // prefix bytes only update the latches in event mode and never occupy a slot
  assign push = good_v & ~(EVENT_MODE != 0 && (good_b == PS2_EXT_PREFIX || good_b == PS2_BRK_PREFIX));
  ps2_sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .clrn(clrn),
    .push(push),
    .pop(rd_en),
    .wr_data({ext_l, brk_l, good_b}),
    .rd_data(head),
    .full(full),
    .empty(empty),
    .count(fifo_count)
  );
  assign out_valid = ~empty;
  assign {out_ext, out_brk, out_data} = head;
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) overflow <= 1'b0;
    else overflow <= (overflow & ~err_clr) | (push & full & ~rd_en);
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: raw and event-mode receivers driven by one PS/2 host model, checked against a queue model
module tb_ps2_rx_fifo;
  localparam int DEPTH = 8, FL = 4, TO = 200, H = 12;
  logic clk = 0, clrn = 0, ps2_clk = 1, ps2_data = 1, rd_en = 0, err_clr = 0;
  logic dv[2], dx[2], db[2], dov[2], dpe[2], dfe[2];
  logic [7:0] dd[2];
  logic [3:0] dc[2];
  int checks = 0, failures = 0;
  bit settled = 0;
  logic [9:0] q [2][$];
  bit ov[2], pe[2], fe[2], lx[2], lb[2];

  always #5 clk = ~clk;

  ps2_rx_fifo #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(FL), .TIMEOUT_CYC(TO), .EVENT_MODE(0)) u_raw (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_en(rd_en), .err_clr(err_clr),
    .out_valid(dv[0]), .out_data(dd[0]), .out_ext(dx[0]), .out_brk(db[0]), .fifo_count(dc[0]),
    .overflow(dov[0]), .parity_err(dpe[0]), .frame_err(dfe[0]));
  ps2_rx_fifo #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(FL), .TIMEOUT_CYC(TO), .EVENT_MODE(1)) u_evt (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_en(rd_en), .err_clr(err_clr),
    .out_valid(dv[1]), .out_data(dd[1]), .out_ext(dx[1]), .out_brk(db[1]), .fifo_count(dc[1]),
    .overflow(dov[1]), .parity_err(dpe[1]), .frame_err(dfe[1]));

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      q[m].delete();
      ov[m] = 0; pe[m] = 0; fe[m] = 0; lx[m] = 0; lb[m] = 0;
    end
  endtask

  task automatic model_pop();
    for (int m = 0; m < 2; m++) if (q[m].size() != 0) void'(q[m].pop_front());
  endtask

  task automatic model_clr();
    for (int m = 0; m < 2; m++) begin
      ov[m] = 0; pe[m] = 0; fe[m] = 0;
    end
  endtask

  task automatic model_abort();
    for (int m = 0; m < 2; m++) begin
      fe[m] = 1; lx[m] = 0; lb[m] = 0;
    end
  endtask

  task automatic model_frame(input logic [7:0] b, input bit pok, input bit sok);
    for (int m = 0; m < 2; m++) begin
      if (!pok) pe[m] = 1;
      if (!sok) fe[m] = 1;
      if (!(pok && sok)) begin
        lx[m] = 0; lb[m] = 0;
      end else if (m == 1 && b == 8'hE0) lx[m] = 1;
      else if (m == 1 && b == 8'hF0) lb[m] = 1;
      else begin
        if (q[m].size() == DEPTH) ov[m] = 1;
        else q[m].push_back({lx[m], lb[m], b});
        lx[m] = 0; lb[m] = 0;
      end
    end
  endtask

  // one compare per settled cycle, after the DUT has absorbed the edge
  always @(posedge clk) begin
    #1;
    if (settled)
      for (int m = 0; m < 2; m++) begin
        logic [9:0] h;
        string nm;
        h = (q[m].size() != 0) ? q[m][0] : 10'd0;
        nm = m ? "evt" : "raw";
        chk({nm, " out_valid"}, dv[m], q[m].size() != 0);
        chk({nm, " out_data"}, dd[m], h[7:0]);
        chk({nm, " out_ext"}, dx[m], h[9]);
        chk({nm, " out_brk"}, db[m], h[8]);
        chk({nm, " fifo_count"}, dc[m], q[m].size());
        chk({nm, " overflow"}, dov[m], ov[m]);
        chk({nm, " parity_err"}, dpe[m], pe[m]);
        chk({nm, " frame_err"}, dfe[m], fe[m]);
      end
  end

  // kind: 0 good, 1 bad parity, 2 bad stop, 3 both, 4 lone edge with data high, 5 timeout, 6 reset mid-frame
  task automatic send(input logic [7:0] b, input int kind, input int glitch, input bit pop_sync);
    logic [10:0] f;
    f = {~(kind == 2 || kind == 3), (~^b) ^ (kind == 1 || kind == 3), b, 1'b0};
    settled = 0;
    if (kind == 4) begin
      ps2_data = 1;
      repeat (6) @(negedge clk);
      ps2_clk = 0;
      repeat (H) @(negedge clk);
      ps2_clk = 1;
      repeat (8) @(negedge clk);
    end else
      for (int i = 0; i < 11; i++) begin
        if (kind == 5 && i == 6) break;
        if (kind == 6 && i == 4) begin
          clrn = 0;
          model_reset();
          #1;
          chk("midframe reset out_valid", dv[0], 0);
          chk("midframe reset fifo_count", dc[1], 0);
          repeat (2) @(negedge clk);
          clrn = 1;
          break;
        end
        ps2_data = f[i];
        repeat (6) @(negedge clk);
        ps2_clk = 0;
        if (i == 10 && pop_sync) begin
          // the FIFO write lands on the 9th rising clk edge after the stop-bit fall is driven
          repeat (8) @(negedge clk);
          rd_en = 1;
          @(negedge clk);
          rd_en = 0;
          repeat (H - 9) @(negedge clk);
        end else repeat (H) @(negedge clk);
        ps2_clk = 1;
        repeat (8) @(negedge clk);
        if (glitch != 0 && i == 4) begin
          ps2_clk = 0;
          repeat (glitch) @(negedge clk);
          ps2_clk = 1;
          repeat (8) @(negedge clk);
        end
      end
    ps2_data = 1;
    repeat (20) @(negedge clk);
    if (kind == 5) repeat (TO + 20) @(negedge clk);
    if (pop_sync) model_pop();
    if (kind <= 3) model_frame(b, !(kind == 1 || kind == 3), !(kind == 2 || kind == 3));
    else if (kind == 4 || kind == 5) model_abort();
    settled = 1;
  endtask

  task automatic ops(input int n, input bit all_pop);
    for (int i = 0; i < n; i++) begin
      rd_en = all_pop ? 1'b1 : 1'($urandom_range(0, 1));
      err_clr = all_pop ? 1'b0 : ($urandom_range(0, 7) == 0);
      if (rd_en) model_pop();
      if (err_clr) model_clr();
      @(negedge clk);
    end
    rd_en = 0;
    err_clr = 0;
  endtask

  task automatic clear();
    err_clr = 1;
    model_clr();
    @(negedge clk);
    err_clr = 0;
  endtask

  initial begin
    logic [7:0] b;
    int k;
    repeat (3) @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      chk("reset out_valid", dv[m], 0);
      chk("reset out_data", dd[m], 0);
      chk("reset fifo_count", dc[m], 0);
      chk("reset flags", {dov[m], dpe[m], dfe[m], dx[m], db[m]}, 0);
    end
    clrn = 1;
    model_reset();
    settled = 1;
    repeat (5) @(negedge clk);
    send(8'h1C, 0, 0, 0);
    chk("t1 out_data", dd[0], 8'h1C);
    chk("t1 out_valid", dv[0], 1);
    chk("t1 fifo_count", dc[0], 1);
    ops(1, 1);
    chk("t1 after pop out_valid", dv[0], 0);
    send(8'hE0, 0, 0, 0);
    send(8'hF0, 0, 0, 0);
    send(8'h75, 0, 0, 0);
    chk("t2 evt count", dc[1], 1);
    chk("t2 evt entry", {dx[1], db[1], dd[1]}, {2'b11, 8'h75});
    chk("t2 raw count", dc[0], 3);
    send(8'h1C, 0, 0, 0);
    ops(1, 1);
    chk("t2 evt second entry", {dx[1], db[1], dd[1]}, {2'b00, 8'h1C});
    ops(10, 1);
    send(8'h1C, 1, 0, 0);
    chk("t3 parity_err", dpe[0], 1);
    chk("t3 no push", dc[0], 0);
    clear();
    chk("t3 parity_err cleared", dpe[0], 0);
    send(8'hA5, 5, 0, 0);
    chk("t4 frame_err", dfe[0], 1);
    send(8'h29, 0, 0, 0);
    chk("t4 after timeout data", dd[0], 8'h29);
    clear();
    ops(10, 1);
    for (int i = 0; i < 9; i++) send(8'h10 + 8'(i), 0, 0, 0);
    chk("t5 full count", dc[0], 8);
    chk("t5 overflow", dov[0], 1);
    chk("t5 head", dd[0], 8'h10);
    send(8'h55, 0, 0, 1);
    chk("t5 pop+push count", dc[0], 8);
    chk("t5 pop+push head", dd[0], 8'h11);
    clear();
    ops(10, 1);
    for (int g = 1; g < FL; g++) send(8'h3A, 0, g, 0);
    chk("t6 glitch count", dc[0], 3);
    chk("t6 glitch data", dd[0], 8'h3A);
    send(8'h66, 6, 0, 0);
    send(8'h4B, 0, 0, 0);
    chk("t6 after reset data", dd[1], 8'h4B);
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 5);
      b = (k == 0) ? 8'hE0 : (k == 1) ? 8'hF0 : 8'($urandom);
      k = $urandom_range(0, 19);
      send(b, (k < 14) ? 0 : k - 13, (k < 14) ? $urandom_range(0, FL - 1) : 0, 0);
      ops($urandom_range(0, 6), 0);
    end
    ops(12, 1);
    settled = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
